// File: rtl/aurora_rx_checker.sv
// Aurora RX frame checker: validates fixed two-word frames, counts good/bad/timeout events.
// Optional macro AURORA_RX_BACKPRESSURE_EN: drops tready one cycle in four.
module aurora_rx_checker #(
  parameter logic [31:0] EXP_WORD0      = 32'h0000_0005,
  parameter logic [31:0] EXP_WORD1      = 32'h0000_0003,
  parameter int          FRAME_LEN      = 2,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          CNT_W          = 16
) (
  input  logic             user_clk,
  input  logic             reset_n,
  input  logic             s_axis_tvalid,
  input  logic [31:0]      s_axis_tdata,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  input  logic             enable,
  input  logic             clear_counters,
  output logic             frame_done,
  output logic             frame_err,
  output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] bad_count,
  output logic [CNT_W-1:0] timeout_count,
  output logic             link_ok,
  output logic [31:0]      last_data,
  output logic [1:0]       fsm_state
);

  // Handshake: a beat transfers on a rising edge where s_axis_tvalid and
  // s_axis_tready are both high; tvalid/tdata/tlast must hold until then.

  localparam int IDX_W  = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDLE_W-1:0] TO_VAL   = IDLE_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BODY = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               accept, match, timeout_hit;
  logic               done_set, err_set;
  logic               bp_ok_next;
  logic [31:0]        exp_word;

  assign accept      = s_axis_tvalid & s_axis_tready;
  assign exp_word    = (idx == '0) ? EXP_WORD0 : EXP_WORD1;
  assign match       = (s_axis_tdata == exp_word);
  assign timeout_hit = !accept && enable && (idle_cnt == TO_VAL - 1'b1);
  assign fsm_state   = state;

`ifdef AURORA_RX_BACKPRESSURE_EN
  logic [1:0] bp_cnt, bp_cnt_next;
  assign bp_cnt_next = bp_cnt + 2'd1;
  // tready is registered, so it follows the counter value it will see next.
  assign bp_ok_next  = (bp_cnt_next != 2'd3);

  always_ff @(posedge user_clk) begin
    if (!reset_n) bp_cnt <= 2'd0;
    else          bp_cnt <= bp_cnt_next;
  end
`else
  assign bp_ok_next = 1'b1;
`endif

  always_comb begin
    state_next = state;
    idx_next   = idx;
    done_set   = 1'b0;
    err_set    = 1'b0;
    if (accept) begin
      case (state)
        S_IDLE: begin
          idx_next = '0;
          if (match && !s_axis_tlast) begin
            state_next = S_BODY;
            idx_next   = IDX_W'(1);
          end else begin
            err_set    = 1'b1;
            state_next = (!match && !s_axis_tlast) ? S_DROP : S_IDLE;
          end
        end
        S_BODY: begin
          if (idx != LAST_IDX) begin
            if (s_axis_tlast) begin
              err_set    = 1'b1;
              state_next = S_IDLE;
              idx_next   = '0;
            end else if (!match) begin
              err_set    = 1'b1;
              state_next = S_DROP;
              idx_next   = '0;
            end else begin
              idx_next = idx + 1'b1;
            end
          end else begin
            idx_next = '0;
            if (s_axis_tlast) begin
              done_set   = match;
              err_set    = !match;
              state_next = S_IDLE;
            end else begin
              err_set    = 1'b1;
              state_next = S_DROP;
            end
          end
        end
        S_DROP: begin
          idx_next = '0;
          if (s_axis_tlast) state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
          idx_next   = '0;
        end
      endcase
    end else if (timeout_hit) begin
      // A stalled frame is abandoned quietly; the timeout counter records it.
      state_next = S_IDLE;
      idx_next   = '0;
    end
  end

  always_ff @(posedge user_clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      idle_cnt      <= '0;
      s_axis_tready <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      link_ok       <= 1'b0;
      last_data     <= 32'd0;
    end else begin
      state         <= state_next;
      idx           <= idx_next;
      s_axis_tready <= enable & bp_ok_next;
      frame_done    <= done_set;
      frame_err     <= err_set;
      if (accept) last_data <= s_axis_tdata;
      // idle_cnt parks at TO_VAL so a single idle stretch times out only once.
      if (accept)                            idle_cnt <= '0;
      else if (enable && idle_cnt != TO_VAL) idle_cnt <= idle_cnt + 1'b1;
      if (done_set)                    link_ok <= 1'b1;
      else if (err_set || timeout_hit) link_ok <= 1'b0;
    end
  end

  always_ff @(posedge user_clk) begin
    if (!reset_n || clear_counters) begin
      good_count    <= '0;
      bad_count     <= '0;
      timeout_count <= '0;
    end else begin
      if (done_set && good_count != '1)       good_count    <= good_count + 1'b1;
      if (err_set && bad_count != '1)         bad_count     <= bad_count + 1'b1;
      if (timeout_hit && timeout_count != '1) timeout_count <= timeout_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_aurora_rx_checker.sv
// Directed bench for aurora_rx_checker: frame checks, watchdog, counter clear, stall, reset.
module tb_aurora_rx_checker;

  logic        user_clk = 1'b0;
  logic        reset_n;
  logic        s_axis_tvalid;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        enable;
  logic        clear_counters;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] good_count;
  logic [15:0] bad_count;
  logic [15:0] timeout_count;
  logic        link_ok;
  logic [31:0] last_data;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_err  = 0;
  int cyc    = 0;

  aurora_rx_checker dut (
    .user_clk       (user_clk),
    .reset_n        (reset_n),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .enable         (enable),
    .clear_counters (clear_counters),
    .frame_done     (frame_done),
    .frame_err      (frame_err),
    .good_count     (good_count),
    .bad_count      (bad_count),
    .timeout_count  (timeout_count),
    .link_ok        (link_ok),
    .last_data      (last_data),
    .fsm_state      (fsm_state)
  );

  // clock / reset block
  always #5 user_clk = ~user_clk;
  always @(posedge user_clk) cyc <= cyc + 1;
  always @(negedge user_clk) begin
    if (frame_done) n_done <= n_done + 1;
    if (frame_err)  n_err  <= n_err + 1;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL global_timeout sim time expired, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "bench time limit");
  end

  // driver tasks
  task automatic do_reset();
    reset_n        = 1'b0;
    s_axis_tvalid  = 1'b0;
    s_axis_tdata   = 32'd0;
    s_axis_tlast   = 1'b0;
    enable         = 1'b1;
    clear_counters = 1'b0;
    repeat (2) begin @(posedge user_clk); #1; end
    reset_n = 1'b1;
    @(posedge user_clk); #1;
    n_done = 0;
    n_err  = 0;
  endtask

  // Returns #1 after the accepting edge, tvalid still high for back-to-back use.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int waited = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    while (!s_axis_tready && waited < 50) begin
      @(posedge user_clk); #1;
      waited++;
    end
    if (!s_axis_tready) begin
      checks++; errors++;
      $display("FAIL ready_wait tready=0 expected 1 after %0d cycles", waited);
    end
    @(posedge user_clk); #1;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) begin @(posedge user_clk); #1; end
  endtask

  task automatic good_frame();
    send_beat(32'd5, 1'b0);
    send_beat(32'd3, 1'b1);
    idle(1);
  endtask

  // tests
  task automatic test_reset();
    reset_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = 32'd0; s_axis_tlast = 1'b0;
    enable = 1'b1; clear_counters = 1'b0;
    repeat (3) begin @(posedge user_clk); #1; end
    checks++;
    if ({s_axis_tready, frame_done, frame_err, link_ok, fsm_state} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b expected 000000",
               {s_axis_tready, frame_done, frame_err, link_ok, fsm_state});
    end
    checks++;
    if ({good_count, bad_count, timeout_count, last_data} !== 80'd0) begin
      errors++;
      $display("FAIL reset_counts good=%0d bad=%0d to=%0d last=%0h expected all 0",
               good_count, bad_count, timeout_count, last_data);
    end
    reset_n = 1'b1;
    @(posedge user_clk); #1;
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++; $display("FAIL reset_tready_rise got %b expected 1", s_axis_tready);
    end
  endtask

  task automatic test_good_frames();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send_beat(32'd5, 1'b0);
      send_beat(32'd3, 1'b1);
      checks++;
      if (frame_done !== 1'b1) begin
        errors++; $display("FAIL good_pulse frame %0d got %b expected 1", i, frame_done);
      end
      idle(256);
    end
    checks++;
    if (n_done !== 10 || n_err !== 0) begin
      errors++; $display("FAIL good_pulse_count done=%0d err=%0d expected 10 0", n_done, n_err);
    end
    checks++;
    if ({good_count, bad_count} !== {16'd10, 16'd0}) begin
      errors++; $display("FAIL good_counts good=%0d bad=%0d expected 10 0", good_count, bad_count);
    end
    checks++;
    if (link_ok !== 1'b1 || last_data !== 32'd3) begin
      errors++; $display("FAIL good_link link_ok=%b last=%0h expected 1 3", link_ok, last_data);
    end
  endtask

  task automatic test_bad_data();
    do_reset();
    good_frame();
    send_beat(32'd5, 1'b0);
    send_beat(32'd4, 1'b1);
    checks++;
    if ({frame_err, frame_done, link_ok} !== 3'b100 || bad_count !== 16'd1) begin
      errors++;
      $display("FAIL bad_data err/done/link=%b bad=%0d expected 100 1",
               {frame_err, frame_done, link_ok}, bad_count);
    end
    idle(1);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL bad_pulse_width got %b expected 0", frame_err);
    end
    good_frame();
    checks++;
    if (link_ok !== 1'b1 || good_count !== 16'd2) begin
      errors++; $display("FAIL bad_recover link=%b good=%0d expected 1 2", link_ok, good_count);
    end
  endtask

  task automatic test_early_tlast_drop();
    do_reset();
    send_beat(32'd5, 1'b1);
    checks++;
    if (frame_err !== 1'b1 || fsm_state !== 2'd0) begin
      errors++; $display("FAIL early_tlast err=%b state=%0d expected 1 0", frame_err, fsm_state);
    end
    send_beat(32'd5, 1'b0);
    send_beat(32'd3, 1'b0);
    checks++;
    if (frame_err !== 1'b1 || fsm_state !== 2'd2) begin
      errors++; $display("FAIL missing_tlast err=%b state=%0d expected 1 2", frame_err, fsm_state);
    end
    send_beat(32'd3, 1'b1);
    checks++;
    if (frame_err !== 1'b0 || fsm_state !== 2'd0) begin
      errors++; $display("FAIL drop_exit err=%b state=%0d expected 0 0", frame_err, fsm_state);
    end
    idle(2);
    checks++;
    if (bad_count !== 16'd2 || n_err !== 2) begin
      errors++; $display("FAIL drop_counts bad=%0d pulses=%0d expected 2 2", bad_count, n_err);
    end
    send_beat(32'd7, 1'b0);
    checks++;
    if (frame_err !== 1'b1 || fsm_state !== 2'd2) begin
      errors++; $display("FAIL idle_mismatch err=%b state=%0d expected 1 2", frame_err, fsm_state);
    end
    send_beat(32'd3, 1'b1);
    good_frame();
    checks++;
    if ({good_count, bad_count} !== {16'd1, 16'd3}) begin
      errors++; $display("FAIL drop_final good=%0d bad=%0d expected 1 3", good_count, bad_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_beat(32'd5, 1'b0);
    send_beat(32'd3, 1'b1);
    idle(1023);
    checks++;
    if (timeout_count !== 16'd0 || link_ok !== 1'b1) begin
      errors++; $display("FAIL timeout_early to=%0d link=%b expected 0 1", timeout_count, link_ok);
    end
    idle(1);
    checks++;
    if (timeout_count !== 16'd1 || link_ok !== 1'b0) begin
      errors++; $display("FAIL timeout_hit to=%0d link=%b expected 1 0", timeout_count, link_ok);
    end
    idle(1500);
    checks++;
    if (timeout_count !== 16'd1) begin
      errors++; $display("FAIL timeout_once to=%0d expected 1", timeout_count);
    end
    send_beat(32'd5, 1'b0);
    idle(1024);
    checks++;
    if (timeout_count !== 16'd2 || bad_count !== 16'd0 || fsm_state !== 2'd0 || n_err !== 0) begin
      errors++;
      $display("FAIL timeout_body to=%0d bad=%0d state=%0d pulses=%0d expected 2 0 0 0",
               timeout_count, bad_count, fsm_state, n_err);
    end
    good_frame();
    checks++;
    if (good_count !== 16'd2 || link_ok !== 1'b1) begin
      errors++; $display("FAIL timeout_recover good=%0d link=%b expected 2 1", good_count, link_ok);
    end
  endtask

  task automatic test_clear_counters();
    do_reset();
    good_frame();
    send_beat(32'd5, 1'b0);
    send_beat(32'd4, 1'b1);
    idle(1);
    send_beat(32'd5, 1'b0);
    clear_counters = 1'b1;
    send_beat(32'd3, 1'b1);
    clear_counters = 1'b0;
    checks++;
    if ({good_count, bad_count, timeout_count} !== 48'd0) begin
      errors++;
      $display("FAIL clear_counts good=%0d bad=%0d to=%0d expected 0 0 0",
               good_count, bad_count, timeout_count);
    end
    checks++;
    if (frame_done !== 1'b1 || link_ok !== 1'b1) begin
      errors++; $display("FAIL clear_pulse done=%b link=%b expected 1 1", frame_done, link_ok);
    end
    good_frame();
    checks++;
    if (good_count !== 16'd1) begin
      errors++; $display("FAIL clear_release good=%0d expected 1", good_count);
    end
  endtask

  task automatic test_back_to_back();
    int start;
    int elapsed;
    int low_cnt = 0;
    do_reset();
    start = cyc;
    for (int i = 0; i < 4; i++) begin
      send_beat(32'd5, 1'b0);
      send_beat(32'd3, 1'b1);
    end
    elapsed = cyc - start;
    idle(1);
    checks++;
    if (good_count !== 16'd4 || n_done !== 4 || bad_count !== 16'd0) begin
      errors++;
      $display("FAIL b2b_counts good=%0d pulses=%0d bad=%0d expected 4 4 0",
               good_count, n_done, bad_count);
    end
    for (int i = 0; i < 8; i++) begin
      if (!s_axis_tready) low_cnt++;
      @(posedge user_clk); #1;
    end
`ifdef AURORA_RX_BACKPRESSURE_EN
    checks++;
    if (low_cnt !== 2) begin
      errors++; $display("FAIL bp_pattern low=%0d expected 2 of 8", low_cnt);
    end
`else
    checks++;
    if (low_cnt !== 0 || elapsed !== 8) begin
      errors++; $display("FAIL b2b_rate low=%0d cycles=%0d expected 0 8", low_cnt, elapsed);
    end
`endif
  endtask

  task automatic test_enable_stall();
    do_reset();
    enable = 1'b0;
    idle(1);
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++; $display("FAIL stall_tready got %b expected 0", s_axis_tready);
    end
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'd5; s_axis_tlast = 1'b0;
    repeat (5) begin @(posedge user_clk); #1; end
    idle(2000);
    checks++;
    if (timeout_count !== 16'd0 || last_data !== 32'd0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL stall_hold to=%0d last=%0h state=%0d expected 0 0 0",
               timeout_count, last_data, fsm_state);
    end
    enable = 1'b1;
    idle(1);
    good_frame();
    checks++;
    if (good_count !== 16'd1 || s_axis_tready !== 1'b1) begin
      errors++; $display("FAIL stall_resume good=%0d rdy=%b expected 1 1", good_count, s_axis_tready);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    good_frame();
    send_beat(32'd5, 1'b0);
    s_axis_tvalid = 1'b0;
    reset_n = 1'b0;
    n_done = 0; n_err = 0;
    @(posedge user_clk); #1;
    reset_n = 1'b1;
    checks++;
    if ({frame_done, frame_err, link_ok, s_axis_tready, good_count, last_data} !== 52'd0) begin
      errors++;
      $display("FAIL midreset_state done=%b err=%b link=%b rdy=%b good=%0d last=%0h expected all 0",
               frame_done, frame_err, link_ok, s_axis_tready, good_count, last_data);
    end
    send_beat(32'd3, 1'b1);
    checks++;
    if (frame_err !== 1'b1 || bad_count !== 16'd1 || n_done !== 0) begin
      errors++;
      $display("FAIL midreset_orphan err=%b bad=%0d done_pulses=%0d expected 1 1 0",
               frame_err, bad_count, n_done);
    end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_good_frames();
    test_bad_data();
    test_early_tlast_drop();
    test_timeout();
    test_clear_counters();
    test_back_to_back();
    test_enable_stall();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aurora_rx_checker.md
# aurora_rx_checker

Receive-side frame checker for the augmented-Aurora link. It sits on the Aurora AXI-Stream master output in the user clock domain and consumes every received beat. Each frame is checked against the two-word constant pattern that the transmit-side stimulus sends. It reports per-frame pulses, saturating good/bad/timeout counters and a link-health flag for ILA probing or register readout.

## Interface

- EXP_WORD0, 32'h0000_0005, required value of beat 0 of every frame
- EXP_WORD1, 32'h0000_0003, required value of every beat after beat 0
- FRAME_LEN, 2, beats per frame, ≥ 2; tlast required on beat FRAME_LEN-1
- TIMEOUT_CYCLES, 1024, idle cycles without an accepted beat before a timeout is declared, ≥ 2
- CNT_W, 16, counter width

- user_clk  in  1  user clock from the Aurora core; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- s_axis_tvalid  in  1  beat valid from the Aurora master interface
- s_axis_tdata  in  32  beat data
- s_axis_tlast  in  1  last beat of frame
- s_axis_tready  out  1  checker ready
- enable  in  1  1 = consume and check; 0 = stall (tready low, all state held)
- clear_counters  in  1  synchronous clear of all counters
- frame_done  out  1  one-cycle pulse, frame received correctly
- frame_err  out  1  one-cycle pulse, frame failed a check
- good_count  out  CNT_W  frames received correctly, saturating
- bad_count  out  CNT_W  frames in error, saturating
- timeout_count  out  CNT_W  timeout events, saturating
- link_ok  out  1  1 after a good frame; 0 after an error or timeout
- last_data  out  32  tdata of the most recent accepted beat

## Operation

- Accept = s_axis_tvalid & s_axis_tready on a rising edge.
- s_axis_tready = enable & bp_ok. bp_ok is 1 unless AURORA_RX_BACKPRESSURE_EN is defined (see Configuration).
- Beat index register idx, width clog2(FRAME_LEN). Expected value is EXP_WORD0 when idx=0, EXP_WORD1 otherwise.
- S_IDLE: waits for beat 0.
  - Accept with match and no tlast → S_BODY, idx=1.
  - Mismatch with tlast → frame_err, stay in S_IDLE.
  - Mismatch without tlast, or match with tlast (early) → frame_err. Mismatch without tlast → S_DROP; early tlast → stay in S_IDLE.
- S_BODY: each accept compares data.
  - idx<FRAME_LEN-1: tlast is an error (→ frame_err, S_IDLE). Mismatch without tlast → frame_err, S_DROP. Match without tlast → idx+1.
  - idx=FRAME_LEN-1: match with tlast → frame_done, S_IDLE. Mismatch with tlast → frame_err, S_IDLE. Any beat without tlast → frame_err, S_DROP.
- S_DROP: discards beats, with no further pulses, until an accepted beat carries tlast → S_IDLE, idx=0.
- Only one pulse is issued per frame.
- Counters:
  - frame_done increments good_count.
  - frame_err increments bad_count.
  - A timeout increments timeout_count.
  - All counters saturate at all-ones.
- link_ok:
  - Set by frame_done.
  - Cleared by frame_err or a timeout.
- Watchdog:
  - idle_cnt clears on accept and otherwise increments while enable=1.
  - On reaching TIMEOUT_CYCLES, timeout_count increments once, link_ok clears and idle_cnt holds until the next accept.
  - A timeout in S_BODY or S_DROP forces S_IDLE and idx=0, with no frame_err.
  - enable=0 freezes idle_cnt.
- clear_counters zeroes all three counters. If it coincides with an increment, the clear wins. It does not affect state, link_ok or pulses.

## Timing

- Reset values: s_axis_tready 0, frame_done 0, frame_err 0, all counts 0, link_ok 0, last_data 0, state S_IDLE, idx 0, idle_cnt 0.
- s_axis_tready rises the first cycle after reset_n deasserts, provided enable=1. It is registered, derived from the next enable and bp_ok.
- frame_done/frame_err are registered and high exactly one cycle, in the cycle after the accepting edge of the terminating beat. Counters and link_ok update on the same edge as the pulse.
- last_data updates on the edge after every accept.
- Timeout is declared on the edge where idle_cnt reaches TIMEOUT_CYCLES. That is TIMEOUT_CYCLES idle enabled cycles after the last accept.
- Full throughput: one beat per cycle with no bubbles while bp_ok=1.
- reset_n low mid-frame aborts the frame silently with no pulses; all registers return to their reset values.

## Configuration

- AURORA_RX_BACKPRESSURE_EN defined: a free-running 2-bit counter drives bp_ok=0 whenever the counter is 3, giving tready low one cycle in four to exercise Aurora-side back-pressure. The counter resets to 0.
- Not defined: bp_ok is tied to 1 and the counter is absent.

## Test plan

- Reset, enable=1, frames {5,3(tlast)} every 258 cycles, ×10 → ten frame_done pulses, good_count=10, bad_count=0, link_ok=1, last_data=3.
- Frame {5,4(tlast)} after one good frame → frame_err one cycle after beat 2, bad_count=1, link_ok=0; next good frame sets link_ok=1.
- Beat 5 with tlast, then {5,3,3(tlast)} → first: early-tlast error. Second: error at beat 2, S_DROP, third beat dropped with no extra pulse. bad_count=2, then a good frame gives good_count=1.
- No input for 1024 cycles after a good frame → timeout_count=1 exactly once, link_ok=0. Beat 5 and then 1024 idle cycles → timeout_count=2 with bad_count unchanged.
- clear_counters asserted on the same edge as a frame_done → all counts 0 afterwards, link_ok=1. With the macro defined, continuous valid → tready pattern 1,1,1,0 repeating and every frame still passes.
- reset_n pulsed low for one cycle between beats 5 and 3 → no pulses, all outputs 0. The orphan beat 3 with tlast is then flagged as a mismatch frame_err.
